// File: rtl/top_k_tracker.sv
// Streaming top-K tracker: keeps the K largest samples in descending order
// (slot 0 = largest) with dedup, sync clear, rank readout and eviction report.
module top_k_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int IDX_W      = (K > 1) ? $clog2(K) : 1,
    parameter int CNT_W      = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  dedup,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  evict_valid,
    output logic [DATA_WIDTH-1:0] evict_data
);

    logic [K-1:0][DATA_WIDTH-1:0] val_q, val_d, val_up;
    logic [K-1:0]                 vld_q, vld_d, vld_up;
    logic [K-1:0]                 ge, eq, ge_prev;
    logic [CNT_W-1:0]             count_q;
    logic                         dup_hit, insert;

    // Parallel compare; valid slots are a sorted prefix so ge is a thermometer code.
    for (genvar i = 0; i < K; i++) begin : g_cmp
        assign ge[i] = vld_q[i] && (val_q[i] >= din);
        assign eq[i] = vld_q[i] && (val_q[i] == din);
    end

    assign ge_prev = {ge[K-2:0], 1'b1};
    assign val_up  = {val_q[K-2:0], {DATA_WIDTH{1'b0}}};
    assign vld_up  = {vld_q[K-2:0], 1'b0};
    assign dup_hit = dedup && (|eq);
    assign insert  = din_valid && !clear && !dup_hit && !ge[K-1];

    // Slot i keeps its value if it ranks above din, takes din at the insertion
    // point, otherwise takes its upper neighbour.
    always_comb begin
        val_d = val_q;
        vld_d = vld_q;
        if (clear) begin
            val_d = '0;
            vld_d = '0;
        end else if (insert) begin
            for (int i = 0; i < K; i++) begin
                if (!ge[i]) begin
                    if (ge_prev[i]) begin
                        val_d[i] = din;
                        vld_d[i] = 1'b1;
                    end else begin
                        val_d[i] = val_up[i];
                        vld_d[i] = vld_up[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val_q       <= '0;
            vld_q       <= '0;
            count_q     <= '0;
            evict_valid <= 1'b0;
            evict_data  <= '0;
        end else begin
            val_q       <= val_d;
            vld_q       <= vld_d;
            evict_valid <= insert && vld_q[K-1];
            if (insert && vld_q[K-1])
                evict_data <= val_q[K-1];
            if (clear)
                count_q <= '0;
            else if (insert && (count_q != CNT_W'(K)))
                count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

    // rd_idx values at or beyond K match no slot and read as empty.
    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                dout       = val_q[i] & {DATA_WIDTH{vld_q[i]}};
                dout_valid = vld_q[i];
            end
        end
    end

endmodule

// File: tb/tb_top_k_tracker.sv
// Bench for top_k_tracker: K=2,4,5,16 instances share one stimulus stream and
// are checked against a sorted-list scoreboard plus directed expectations.
`timescale 1ns/1ps
module tb_top_k_tracker;

    localparam int KS[4]  = '{2, 4, 5, 16};
    localparam int RNG[4] = '{2, 4, 8, 16};

    logic        clk = 1'b0, resetn = 1'b0, clear = 1'b0, din_valid = 1'b0, dedup = 1'b0;
    logic [31:0] din = '0;
    logic [3:0]  rd_r = '0;

    logic [31:0] dout_a [4];
    logic        dv_a [4];
    logic        ev_a [4];
    logic [31:0] evd_a [4];
    logic [4:0]  cnt_a [4];
    logic [1:0]  cnt2;
    logic [2:0]  cnt4, cnt5;
    logic [4:0]  cnt16;

    assign cnt_a[0] = {3'b0, cnt2};
    assign cnt_a[1] = {2'b0, cnt4};
    assign cnt_a[2] = {2'b0, cnt5};
    assign cnt_a[3] = cnt16;

    int n_cmp = 0, n_bad = 0;

    always #50 clk = ~clk;

    top_k_tracker #(.DATA_WIDTH(32), .K(2)) u_k2 (
        .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
        .dedup(dedup), .rd_idx(rd_r[0:0]), .dout(dout_a[0]), .dout_valid(dv_a[0]),
        .count(cnt2), .evict_valid(ev_a[0]), .evict_data(evd_a[0]));
    top_k_tracker #(.DATA_WIDTH(32), .K(4)) u_k4 (
        .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
        .dedup(dedup), .rd_idx(rd_r[1:0]), .dout(dout_a[1]), .dout_valid(dv_a[1]),
        .count(cnt4), .evict_valid(ev_a[1]), .evict_data(evd_a[1]));
    top_k_tracker #(.DATA_WIDTH(32), .K(5)) u_k5 (
        .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
        .dedup(dedup), .rd_idx(rd_r[2:0]), .dout(dout_a[2]), .dout_valid(dv_a[2]),
        .count(cnt5), .evict_valid(ev_a[2]), .evict_data(evd_a[2]));
    top_k_tracker #(.DATA_WIDTH(32), .K(16)) u_k16 (
        .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
        .dedup(dedup), .rd_idx(rd_r), .dout(dout_a[3]), .dout_valid(dv_a[3]),
        .count(cnt16), .evict_valid(ev_a[3]), .evict_data(evd_a[3]));

    typedef struct packed {
        logic [3:0][4:0]        cnt;
        logic [3:0]             ev;
        logic [3:0][31:0]       evd;
        logic [3:0][15:0][31:0] v;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mv [4][16];
    int          mc [4];
    logic        mev [4];
    logic [31:0] mevd [4];

    task automatic model_reset();
        for (int u = 0; u < 4; u++) begin
            mc[u] = 0; mev[u] = 1'b0; mevd[u] = '0;
            for (int i = 0; i < 16; i++) mv[u][i] = '0;
        end
    endtask

    // Drive one cycle, push the sorted-list model's prediction, then compare.
    task automatic step(input logic c, input logic vld, input logic [31:0] d, input logic dd);
        exp_t e;
        logic        exp_dv;
        logic [31:0] exp_d;
        clear = c; din_valid = vld; din = d; dedup = dd;
        for (int u = 0; u < 4; u++) begin
            int k;
            int p;
            logic hit;
            k = KS[u]; p = 0; hit = 1'b0;
            mev[u] = 1'b0;
            if (c) begin
                mc[u] = 0;
                for (int i = 0; i < 16; i++) mv[u][i] = '0;
            end else if (vld) begin
                for (int i = 0; i < mc[u]; i++) begin
                    if (mv[u][i] == d) hit = 1'b1;
                    if (mv[u][i] >= d) p++;
                end
                if (!(dd && hit) && p < k) begin
                    if (mc[u] == k) begin
                        mev[u] = 1'b1;
                        mevd[u] = mv[u][k-1];
                    end
                    for (int i = k - 1; i > p; i--) mv[u][i] = mv[u][i-1];
                    mv[u][p] = d;
                    if (mc[u] < k) mc[u]++;
                end
            end
            e.cnt[u] = 5'(mc[u]);
            e.ev[u]  = mev[u];
            e.evd[u] = mevd[u];
            for (int i = 0; i < 16; i++) e.v[u][i] = mv[u][i];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        clear = 1'b0; din_valid = 1'b0;
        e = sbq.pop_front();
        for (int u = 0; u < 4; u++) begin
            n_cmp++;
            if (cnt_a[u] !== e.cnt[u]) begin
                n_bad++; $display("FAIL k%0d_count got %0d want %0d", KS[u], cnt_a[u], e.cnt[u]);
            end
            n_cmp++;
            if (ev_a[u] !== e.ev[u]) begin
                n_bad++; $display("FAIL k%0d_evict_valid got %0b want %0b", KS[u], ev_a[u], e.ev[u]);
            end
            n_cmp++;
            if (evd_a[u] !== e.evd[u]) begin
                n_bad++; $display("FAIL k%0d_evict_data got %0d want %0d", KS[u], evd_a[u], e.evd[u]);
            end
        end
        for (int r = 0; r < 16; r++) begin
            rd_r = 4'(r);
            #1;
            for (int u = 0; u < 4; u++) begin
                if (r < RNG[u]) begin
                    exp_dv = (r < KS[u]) && (r < int'(e.cnt[u]));
                    exp_d  = exp_dv ? e.v[u][r] : 32'd0;
                    n_cmp++;
                    if (dout_a[u] !== exp_d || dv_a[u] !== exp_dv) begin
                        n_bad++;
                        $display("FAIL k%0d_rank%0d got %0d/%0b want %0d/%0b",
                                 KS[u], r, dout_a[u], dv_a[u], exp_d, exp_dv);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        #10;
        for (int u = 0; u < 4; u++) begin
            n_cmp++;
            if (cnt_a[u] !== 5'd0 || ev_a[u] !== 1'b0 || evd_a[u] !== 32'd0 ||
                dout_a[u] !== 32'd0 || dv_a[u] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_k%0d got cnt=%0d ev=%0b evd=%0d dout=%0d dv=%0b",
                         KS[u], cnt_a[u], ev_a[u], evd_a[u], dout_a[u], dv_a[u]);
            end
        end
        #10 resetn = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] want [4] = '{32'd9, 32'd7, 32'd5, 32'd1};
        step(0, 1, 5, 0); step(0, 1, 9, 0); step(0, 1, 1, 0); step(0, 1, 7, 0);
        n_cmp++;
        if (cnt_a[1] !== 5'd4) begin n_bad++; $display("FAIL fill_count got %0d want 4", cnt_a[1]); end
        for (int r = 0; r < 4; r++) begin
            rd_r = 4'(r); #1;
            n_cmp++;
            if (dout_a[1] !== want[r]) begin
                n_bad++; $display("FAIL fill_rank%0d got %0d want %0d", r, dout_a[1], want[r]);
            end
        end
    endtask

    task automatic test_evict();
        step(0, 1, 8, 0);
        n_cmp++;
        if (ev_a[1] !== 1'b1 || evd_a[1] !== 32'd1) begin
            n_bad++; $display("FAIL evict_pulse got %0b/%0d want 1/1", ev_a[1], evd_a[1]);
        end
        step(0, 1, 3, 0);
        rd_r = 4'd1; #1;
        n_cmp++;
        if (ev_a[1] !== 1'b0 || dout_a[1] !== 32'd8) begin
            n_bad++; $display("FAIL evict_small got ev=%0b r1=%0d want ev=0 r1=8", ev_a[1], dout_a[1]);
        end
    endtask

    task automatic test_dedup();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 1);
        n_cmp++;
        if (cnt_a[1] !== 5'd1) begin n_bad++; $display("FAIL dedup_on_count got %0d want 1", cnt_a[1]); end
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 0);
        n_cmp++;
        if (cnt_a[1] !== 5'd3) begin n_bad++; $display("FAIL dedup_off_count got %0d want 3", cnt_a[1]); end
    endtask

    task automatic test_clear_priority();
        step(0, 1, 50, 0);
        step(1, 1, 100, 0);
        n_cmp++;
        if (cnt_a[1] !== 5'd0 || cnt_a[3] !== 5'd0) begin
            n_bad++; $display("FAIL clear_prio got %0d/%0d want 0/0", cnt_a[1], cnt_a[3]);
        end
        step(0, 1, 100, 0);
        rd_r = 4'd0; #1;
        n_cmp++;
        if (dout_a[1] !== 32'd100) begin n_bad++; $display("FAIL clear_next got %0d want 100", dout_a[1]); end
    endtask

    task automatic test_idle_and_async_reset();
        step(0, 1, 40, 0); step(0, 1, 2, 0); step(0, 1, 70, 0); step(0, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, $urandom, 1'($urandom_range(0, 1)));
        rd_r = 4'd0;
        #20 resetn = 1'b0;
        #1;
        for (int u = 0; u < 4; u++) begin
            n_cmp++;
            if (cnt_a[u] !== 5'd0 || dout_a[u] !== 32'd0 || ev_a[u] !== 1'b0 || evd_a[u] !== 32'd0) begin
                n_bad++;
                $display("FAIL async_reset_k%0d got cnt=%0d dout=%0d ev=%0b evd=%0d",
                         KS[u], cnt_a[u], dout_a[u], ev_a[u], evd_a[u]);
            end
        end
        model_reset();
        #5 resetn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int n = 0; n < 10000; n++) begin
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) != 0), d,
                 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_evict();
        test_dedup();
        test_clear_priority();
        test_idle_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
